// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one iterative GCD engine between NREQ requesters.
// Define GCD_ARB_TIMEOUT_EN to bound the engine wait with a TIMEOUT-cycle kill.
module gcd_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result,
  output logic              eng_kill
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("gcd_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   grant_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [W-1:0]    rsp_data_q;
  logic            eng_start_q;
  logic [W-1:0]    eng_a_q;
  logic [W-1:0]    eng_b_q;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] grant_oh;
  logic [W-1:0]    gnt_a;
  logic [W-1:0]    gnt_b;

  // Search from ptr upward with wrap; the first set request wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req[(int'(ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
    ptr_d          = PW'((int'(gnt_idx) + 1) % NREQ);
    gnt_oh         = '0;
    gnt_oh[gnt_idx] = 1'b1;
    grant_oh       = '0;
    grant_oh[grant_q] = 1'b1;
    gnt_a          = req_a[int'(gnt_idx)*W +: W];
    gnt_b          = req_b[int'(gnt_idx)*W +: W];
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q;
  logic          rsp_err_q;
  logic          eng_kill_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      tmr_q       <= '0;
      rsp_err_q   <= 1'b0;
      eng_kill_q  <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low here with non-blocking assignments; later
      // assignments in the case below override them within the same edge.
      ack_q       <= '0;
      eng_start_q <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      eng_kill_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            ack_q   <= gnt_oh;
            grant_q <= gnt_idx;
            ptr_q   <= ptr_d;
            eng_a_q <= gnt_a;
            eng_b_q <= gnt_b;
            if (gnt_a == '0 || gnt_b == '0) begin
              // gcd(0,x) = x and gcd(0,0) = 0, so the OR is the answer.
              rsp_data_q <= gnt_a | gnt_b;
              state_q    <= S_RESP;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= S_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
              tmr_q       <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            rsp_data_q  <= eng_result;
            rsp_valid_q <= grant_oh;
            state_q     <= S_RESP;
`ifdef GCD_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            eng_kill_q  <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= grant_oh;
            state_q     <= S_RESP;
          end else begin
            tmr_q <= tmr_q + 1'b1;
`endif
          end
        end
        S_RESP: begin
          // Bypass jobs arrive here without a response yet; engine jobs arrive with it raised.
          if (rsp_valid_q != '0) begin
            rsp_valid_q <= '0;
            state_q     <= S_IDLE;
`ifdef GCD_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end else begin
            rsp_valid_q <= grant_oh;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
`ifdef GCD_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
  assign eng_kill  = eng_kill_q;
`else
  assign rsp_err   = 1'b0;
  assign eng_kill  = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: directed jobs push expectations, a monitor
// pops and compares on every ack, eng_start and rsp_valid.
module tb_gcd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 16;

  typedef enum int {L_BYP, L_ENG, L_TMO} lat_e;
  typedef struct {
    int         idx;
    logic [W-1:0] data;
    logic       err;
    lat_e       lat;
  } rsp_t;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              eng_start;
  logic [W-1:0]      eng_a;
  logic [W-1:0]      eng_b;
  logic              eng_done;
  logic [W-1:0]      eng_result;
  logic              eng_kill;

  gcd_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .eng_kill   (eng_kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  rsp_t rsp_q[$];
  int   ack_q[$];
  op_t  op_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: replies eng_lat+1 cycles after eng_start unless told to hang.
  int           eng_lat  = 2;
  bit           eng_hang = 1'b0;
  int           done_cyc = -100;
  bit           e_busy, e_stable, e_killed;
  int           e_cnt;
  logic [W-1:0] e_a, e_b;

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    e_busy     = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      eng_done = 1'b0;
      if (rst) begin
        if (eng_hang) e_busy = 1'b0;
        else e_killed = 1'b1;
      end
      if (e_busy) begin
        if (eng_kill) begin
          e_busy = 1'b0;
        end else if (!eng_hang) begin
          if (e_cnt == 0) begin
            eng_done   = 1'b1;
            eng_result = gcd(e_a, e_b);
            done_cyc   = cyc;
            e_busy     = 1'b0;
            if (!e_killed) check("eng_ops_stable", 64'(e_stable), 64'd1);
          end else begin
            e_cnt--;
          end
        end
        if (e_busy && !rst && (eng_a !== e_a || eng_b !== e_b)) e_stable = 1'b0;
      end
      if (eng_start) begin
        e_busy   = 1'b1;
        e_cnt    = eng_lat;
        e_a      = eng_a;
        e_b      = eng_b;
        e_stable = 1'b1;
        e_killed = 1'b0;
      end
    end
  end

  // Monitor: compares every DUT presentation against the scoreboard queues.
  int              last_ack_cyc   = -100;
  int              last_rsp_cyc   = -100;
  int              last_start_cyc = -100;
  int              rsp_seen       = 0;
  int              start_seen     = 0;
  rsp_t            m_r;
  op_t             m_o;
  int              m_e;
  logic [NREQ-1:0] m_oh;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack != '0) begin
          check("ack_onehot", 64'($onehot(ack)), 64'd1);
          if (ack_q.size() == 0) begin
            check("ack_unexpected", 64'(ack), 64'd0);
          end else begin
            m_e       = ack_q.pop_front();
            m_oh      = '0;
            m_oh[m_e] = 1'b1;
            check("ack_index", 64'(ack), 64'(m_oh));
          end
          check("ack_spacing", 64'(cyc - last_rsp_cyc >= 2), 64'd1);
          last_ack_cyc = cyc;
        end
        if (eng_start) begin
          start_seen++;
          last_start_cyc = cyc;
          if (op_q.size() == 0) begin
            check("start_unexpected", 64'(eng_start), 64'd0);
          end else begin
            m_o = op_q.pop_front();
            check("eng_a", 64'(eng_a), 64'(m_o.a));
            check("eng_b", 64'(eng_b), 64'(m_o.b));
          end
        end
        if (rsp_valid != '0) begin
          rsp_seen++;
          last_rsp_cyc = cyc;
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            m_r           = rsp_q.pop_front();
            m_oh          = '0;
            m_oh[m_r.idx] = 1'b1;
            check("rsp_index", 64'(rsp_valid), 64'(m_oh));
            check("rsp_data", 64'(rsp_data), 64'(m_r.data));
            check("rsp_err", 64'(rsp_err), 64'(m_r.err));
            check("eng_kill", 64'(eng_kill), 64'(m_r.err));
            case (m_r.lat)
              L_ENG:   check("rsp_lat_eng", 64'(cyc), 64'(done_cyc + 1));
              L_BYP:   check("rsp_lat_byp", 64'(cyc), 64'(last_ack_cyc + 1));
              default: check("rsp_lat_tmo", 64'(cyc), 64'(last_start_cyc + TO));
            endcase
          end
        end
      end
    end
  end

  // Stimulus helpers: requesters drop req on the cycle they see their ack.
  task automatic tick();
    @(negedge clk);
    req = req & ~ack;
  endtask

  task automatic job(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input lat_e lat, input bit want_rsp);
    rsp_t r;
    op_t  o;
    ack_q.push_back(i);
    if (lat != L_BYP) begin
      o.a = a;
      o.b = b;
      op_q.push_back(o);
    end
    if (want_rsp) begin
      r.idx  = i;
      r.data = exp;
      r.err  = (lat == L_TMO);
      r.lat  = lat;
      rsp_q.push_back(r);
    end
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req[i]          = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 2000 && (rsp_q.size() != 0 || ack_q.size() != 0); n++) tick();
    check(name, 64'(rsp_q.size() + ack_q.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 64'({ack, rsp_valid, rsp_err, eng_start, eng_kill}), 64'd0);
    check({name, "_data"}, 64'(rsp_data | eng_a | eng_b), 64'd0);
  endtask

  int s0, r0;

  initial begin
    rst   = 1'b1;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single job with ack/start latency checked directly.
    eng_lat = 4;
    job(0, 15, 6, 3, L_ENG, 1'b1);
    tick();
    check("single_ack_t1", 64'(ack[0]), 64'd1);
    check("single_start_t1", 64'(eng_start), 64'd1);
    drain("single_drain");

    // Large operands, back to back on the same requester.
    eng_lat = 8;
    job(2, 94665, 544257, 3, L_ENG, 1'b1);
    drain("large1_drain");
    eng_lat = 2;
    job(2, 15625, 3125, 3125, L_ENG, 1'b1);
    drain("large2_drain");

    // Fresh reset so ptr is 0, then all four requesters at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_lat = 1;
    job(0, 12, 18, 6, L_ENG, 1'b1);
    job(1, 35, 21, 7, L_ENG, 1'b1);
    job(2, 100, 75, 25, L_ENG, 1'b1);
    job(3, 8, 12, 4, L_ENG, 1'b1);
    drain("fair_round_drain");
    job(1, 9, 6, 3, L_ENG, 1'b1);
    drain("fair_ptr2_drain");
    job(3, 27, 18, 9, L_ENG, 1'b1);
    job(1, 14, 21, 7, L_ENG, 1'b1);
    drain("fair_wrap_drain");

    // Zero bypass: ack at T+1, response at T+2, engine untouched.
    s0 = start_seen;
    job(1, 0, 20, 20, L_BYP, 1'b1);
    tick();
    check("zero_ack_t1", 64'(ack[1]), 64'd1);
    check("zero_nostart_t1", 64'(eng_start), 64'd0);
    tick();
    check("zero_rsp_t2", 64'(rsp_valid[1]), 64'd1);
    drain("zero1_drain");
    job(1, 0, 0, 0, L_BYP, 1'b1);
    drain("zero2_drain");
    job(2, 7, 0, 7, L_BYP, 1'b1);
    drain("zero3_drain");
    check("zero_no_eng_start", 64'(start_seen - s0), 64'd0);

    // Reset during WAIT: job lost, late eng_done ignored, re-request served.
    eng_lat = 20;
    r0 = rsp_seen;
    job(2, 48, 36, 12, L_ENG, 1'b0);
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midjob_reset");
    rst = 1'b0;
    repeat (30) tick();
    check("midjob_no_rsp", 64'(rsp_seen - r0), 64'd0);
    check("midjob_queues_empty", 64'(ack_q.size() + op_q.size()), 64'd0);
    eng_lat = 3;
    job(2, 48, 36, 12, L_ENG, 1'b1);
    drain("rerequest_drain");

    // Engine that never finishes.
    eng_hang = 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
    job(0, 5, 10, 0, L_TMO, 1'b1);
    drain("timeout_drain");
    eng_hang = 1'b0;
`else
    r0 = rsp_seen;
    job(0, 5, 10, 0, L_ENG, 1'b0);
    repeat (1000) tick();
    check("hang_no_rsp_1000", 64'(rsp_seen - r0), 64'd0);
    check("hang_queues_empty", 64'(ack_q.size() + op_q.size()), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_hang = 1'b0;
`endif
    eng_lat = 2;
    job(3, 21, 14, 7, L_ENG, 1'b1);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
